// File: rtl/switch_packet.sv
// Two-port packet switch: per-input single-packet buffers, per-output round-robin
// arbitration and a small config register file for enables, routes and counters.
module switch_packet #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_LEN = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] packet_in_0,
  input  logic [DATA_W-1:0] packet_in_1,
  input  logic              packet_in_start_0,
  input  logic              packet_in_start_1,
  output logic              packet_ack_0,
  output logic              packet_ack_1,
  output logic [DATA_W-1:0] packet_out_0,
  output logic [DATA_W-1:0] packet_out_1,
  output logic              read_data_valid_0,
  output logic              read_data_valid_1,
  output logic              packet_out_start_0,
  output logic              packet_out_start_1,
  input  logic [7:0]        conf_address,
  input  logic [DATA_W-1:0] conf_data_write,
  output logic [DATA_W-1:0] conf_data_read,
  input  logic              conf_data_valid,
  input  logic              conf_read_write
);

  localparam int unsigned DEPTH = MAX_LEN + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DROP} rx_state_e;

  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        in_start;

  rx_state_e         rx_state_q [2];
  rx_state_e         rx_state_d [2];
  logic [DATA_W-1:0] rx_cnt_q [2];
  logic [DATA_W-1:0] rx_cnt_d [2];
  logic [IDX_W-1:0]  rx_idx_q [2];
  logic [IDX_W-1:0]  rx_idx_d [2];
  logic [1:0]        buf_we_c;
  logic [IDX_W-1:0]  buf_wa_c [2];
  logic [1:0]        rx_done_c;
  logic [1:0]        drop_inc_c;

  logic [DATA_W-1:0] mem_q [2][DEPTH];
  logic [1:0]        full_q;
  logic [1:0]        route_q;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] drop_q [2];

  logic [1:0]        tx_busy_q, tx_busy_d;
  logic [1:0]        tx_src_q, tx_src_d;
  logic [IDX_W-1:0]  tx_idx_q [2];
  logic [IDX_W-1:0]  tx_idx_d [2];
  logic [IDX_W-1:0]  tx_len_q [2];
  logic [IDX_W-1:0]  tx_len_d [2];
  logic [1:0]        prio_q, prio_d;
  logic [1:0]        req_c [2];
  logic [1:0]        gnt_c;
  logic [1:0]        last_c;
  logic [1:0]        free_c;
  logic [1:0]        fwd_inc_c;
  logic [DATA_W-1:0] out_data_q [2];
  logic [DATA_W-1:0] out_data_d [2];
  logic [1:0]        out_valid_q, out_valid_d;
  logic [1:0]        out_start_q, out_start_d;
  logic [DATA_W-1:0] fwd_q [2];

  logic [1:0]        ctrl_q;
  logic [1:0]        route_cfg_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_mux_c;

  assign in_data[0] = packet_in_0;
  assign in_data[1] = packet_in_1;
  assign in_start   = {packet_in_start_1, packet_in_start_0};

  // Receive FSM: accept into the buffer, or swallow L+1 bytes when it cannot
  always_comb begin
    buf_we_c   = '0;
    rx_done_c  = '0;
    drop_inc_c = '0;
    for (int i = 0; i < 2; i++) begin
      rx_state_d[i] = rx_state_q[i];
      rx_cnt_d[i]   = rx_cnt_q[i];
      rx_idx_d[i]   = rx_idx_q[i];
      buf_wa_c[i]   = '0;
      case (rx_state_q[i])
        RX_IDLE: begin
          if (in_start[i] && ctrl_q[i]) begin
            if (full_q[i] || (in_data[i] > DATA_W'(MAX_LEN))) begin
              drop_inc_c[i] = 1'b1;
              if (in_data[i] != '0) begin
                rx_state_d[i] = RX_DROP;
                rx_cnt_d[i]   = in_data[i];
              end
            end else begin
              buf_we_c[i] = 1'b1;
              if (in_data[i] == '0) begin
                rx_done_c[i] = 1'b1;
              end else begin
                rx_state_d[i] = RX_RECV;
                rx_cnt_d[i]   = in_data[i];
                rx_idx_d[i]   = IDX_W'(1);
              end
            end
          end
        end
        RX_RECV: begin
          buf_we_c[i] = 1'b1;
          buf_wa_c[i] = rx_idx_q[i];
          rx_idx_d[i] = IDX_W'(rx_idx_q[i] + 1'b1);
          rx_cnt_d[i] = DATA_W'(rx_cnt_q[i] - 1'b1);
          if (rx_cnt_q[i] == DATA_W'(1)) begin
            rx_done_c[i]  = 1'b1;
            rx_state_d[i] = RX_IDLE;
          end
        end
        RX_DROP: begin
          rx_cnt_d[i] = DATA_W'(rx_cnt_q[i] - 1'b1);
          if (rx_cnt_q[i] == DATA_W'(1)) rx_state_d[i] = RX_IDLE;
        end
        default: rx_state_d[i] = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        rx_state_q[i] <= RX_IDLE;
        rx_cnt_q[i]   <= '0;
        rx_idx_q[i]   <= '0;
        drop_q[i]     <= '0;
      end
      full_q  <= '0;
      route_q <= '0;
      ack_q   <= '0;
    end else begin
      ack_q <= rx_done_c;
      for (int i = 0; i < 2; i++) begin
        rx_state_q[i] <= rx_state_d[i];
        rx_cnt_q[i]   <= rx_cnt_d[i];
        rx_idx_q[i]   <= rx_idx_d[i];
        if (buf_we_c[i]) mem_q[i][buf_wa_c[i]] <= in_data[i];
        // Route is frozen at ack so later ROUTE writes cannot redirect this packet
        if (rx_done_c[i]) begin
          full_q[i]  <= 1'b1;
          route_q[i] <= route_cfg_q[i];
        end else if (free_c[i]) begin
          full_q[i] <= 1'b0;
        end
        if (drop_inc_c[i] && (drop_q[i] != '1)) drop_q[i] <= DATA_W'(drop_q[i] + 1'b1);
      end
    end
  end

  // Output engines: finishing source is excluded so a waiting input follows back-to-back
  always_comb begin
    free_c    = '0;
    fwd_inc_c = '0;
    gnt_c     = '0;
    last_c    = '0;
    tx_busy_d = tx_busy_q;
    tx_src_d  = tx_src_q;
    prio_d    = prio_q;
    out_valid_d = '0;
    out_start_d = '0;
    for (int o = 0; o < 2; o++) begin
      tx_idx_d[o]   = tx_idx_q[o];
      tx_len_d[o]   = tx_len_q[o];
      out_data_d[o] = '0;
      for (int i = 0; i < 2; i++) begin
        req_c[o][i] = full_q[i] && (route_q[i] == 1'(o)) &&
                      !(tx_busy_q[o] && (tx_src_q[o] == 1'(i)));
      end
      last_c[o] = tx_busy_q[o] && (tx_idx_q[o] == tx_len_q[o]);
      if (last_c[o]) begin
        free_c[tx_src_q[o]] = 1'b1;
        fwd_inc_c[o]        = 1'b1;
      end
      if (tx_busy_q[o] && !last_c[o]) begin
        tx_idx_d[o]    = IDX_W'(tx_idx_q[o] + 1'b1);
        out_data_d[o]  = mem_q[tx_src_q[o]][IDX_W'(tx_idx_q[o] + 1'b1)];
        out_valid_d[o] = 1'b1;
      end else begin
        tx_busy_d[o] = 1'b0;
        if (req_c[o] != 2'b00) begin
          gnt_c[o] = (req_c[o] == 2'b11) ? prio_q[o] : req_c[o][1];
          if (req_c[o] == 2'b11) prio_d[o] = ~prio_q[o];
          tx_busy_d[o]   = 1'b1;
          tx_src_d[o]    = gnt_c[o];
          tx_idx_d[o]    = '0;
          tx_len_d[o]    = IDX_W'(mem_q[gnt_c[o]][0]);
          out_data_d[o]  = mem_q[gnt_c[o]][0];
          out_valid_d[o] = 1'b1;
          out_start_d[o] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_busy_q   <= '0;
      tx_src_q    <= '0;
      prio_q      <= '0;
      out_valid_q <= '0;
      out_start_q <= '0;
      for (int o = 0; o < 2; o++) begin
        tx_idx_q[o]   <= '0;
        tx_len_q[o]   <= '0;
        out_data_q[o] <= '0;
        fwd_q[o]      <= '0;
      end
    end else begin
      tx_busy_q   <= tx_busy_d;
      tx_src_q    <= tx_src_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      for (int o = 0; o < 2; o++) begin
        tx_idx_q[o]   <= tx_idx_d[o];
        tx_len_q[o]   <= tx_len_d[o];
        out_data_q[o] <= out_data_d[o];
        if (fwd_inc_c[o]) fwd_q[o] <= DATA_W'(fwd_q[o] + 1'b1);
      end
    end
  end

  always_comb begin
    rd_mux_c = '0;
    case (conf_address)
      8'h00:   rd_mux_c = DATA_W'(ctrl_q);
      8'h01:   rd_mux_c = DATA_W'(route_cfg_q[0]);
      8'h02:   rd_mux_c = DATA_W'(route_cfg_q[1]);
      8'h03:   rd_mux_c = drop_q[0];
      8'h04:   rd_mux_c = drop_q[1];
      8'h05:   rd_mux_c = fwd_q[0];
      8'h06:   rd_mux_c = fwd_q[1];
      default: rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q      <= 2'b11;
      route_cfg_q <= 2'b10;
      rdata_q     <= '0;
    end else if (conf_data_valid) begin
      if (conf_read_write) begin
        case (conf_address)
          8'h00:   ctrl_q         <= conf_data_write[1:0];
          8'h01:   route_cfg_q[0] <= conf_data_write[0];
          8'h02:   route_cfg_q[1] <= conf_data_write[0];
          default: ;
        endcase
      end else begin
        rdata_q <= rd_mux_c;
      end
    end
  end

  assign packet_ack_0       = ack_q[0];
  assign packet_ack_1       = ack_q[1];
  assign packet_out_0       = out_data_q[0];
  assign packet_out_1       = out_data_q[1];
  assign read_data_valid_0  = out_valid_q[0];
  assign read_data_valid_1  = out_valid_q[1];
  assign packet_out_start_0 = out_start_q[0];
  assign packet_out_start_1 = out_start_q[1];
  assign conf_data_read     = rdata_q;

endmodule

// File: tb/tb_switch_packet.sv
// Directed, table-driven bench for switch_packet: per-cycle input/expected-output
// records plus register reads around each scenario.
module tb_switch_packet;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pin0, pin1;
  logic       pst0, pst1;
  logic       ack0, ack1;
  logic [7:0] pout0, pout1;
  logic       vld0, vld1, sto0, sto1;
  logic [7:0] caddr, cwdata, crdata;
  logic       cvalid, crw;

  always #5 clk = ~clk;

  switch_packet #(.DATA_W(8), .MAX_LEN(15)) dut (
    .clk(clk), .rst(rst),
    .packet_in_0(pin0), .packet_in_1(pin1),
    .packet_in_start_0(pst0), .packet_in_start_1(pst1),
    .packet_ack_0(ack0), .packet_ack_1(ack1),
    .packet_out_0(pout0), .packet_out_1(pout1),
    .read_data_valid_0(vld0), .read_data_valid_1(vld1),
    .packet_out_start_0(sto0), .packet_out_start_1(sto1),
    .conf_address(caddr), .conf_data_write(cwdata), .conf_data_read(crdata),
    .conf_data_valid(cvalid), .conf_read_write(crw)
  );

  // exp layout: ack0 ack1 | vld0 sto0 out0[8] | vld1 sto1 out1[8]
  typedef struct {
    logic [7:0]  in0;
    logic        st0;
    logic [7:0]  in1;
    logic        st1;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;
  logic [7:0] b22 [7] = '{8'h06, 8'h03, 8'h05, 8'h09, 8'h04, 8'h11, 8'h6F};

  function automatic logic [21:0] e_ack(input logic a0, input logic a1);
    return {a0, a1, 20'b0};
  endfunction
  function automatic logic [21:0] e_o0(input logic s, input logic [7:0] d);
    return {2'b00, 1'b1, s, d, 10'b0};
  endfunction
  function automatic logic [21:0] e_o1(input logic s, input logic [7:0] d);
    return {12'b0, 1'b1, s, d};
  endfunction
  function automatic vec_t mk(input logic [7:0] a, input logic sa, input logic [7:0] b,
                              input logic sb, input logic [21:0] e);
    vec_t r;
    r.in0 = a; r.st0 = sa; r.in1 = b; r.st1 = sb; r.exp = e;
    return r;
  endfunction

  function automatic logic [21:0] outs();
    return {ack0, ack1, vld0, sto0, pout0, vld1, sto1, pout1};
  endfunction

  task automatic run_table(input string name);
    logic [21:0] act;
    for (int k = 0; k < tbl.size(); k++) begin
      pin0 = tbl[k].in0; pst0 = tbl[k].st0;
      pin1 = tbl[k].in1; pst1 = tbl[k].st1;
      @(posedge clk); #1;
      act = outs();
      nvec++;
      if (act !== tbl[k].exp) begin
        nerr++;
        $display("FAIL %s[%0d]: got %h expected %h", name, k, act, tbl[k].exp);
      end
    end
    tbl.delete();
    pin0 = '0; pst0 = 1'b0; pin1 = '0; pst1 = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [7:0] d);
    caddr = a; cwdata = d; crw = 1'b1; cvalid = 1'b1;
    @(posedge clk); #1;
    cvalid = 1'b0; crw = 1'b0;
  endtask

  task automatic chk_reg(input logic [7:0] a, input logic [7:0] e, input string name);
    caddr = a; crw = 1'b0; cvalid = 1'b1;
    @(posedge clk); #1;
    cvalid = 1'b0;
    check(name, 32'(crdata), 32'(e));
  endtask

  // Garbage start byte during reset must be ignored
  task automatic do_reset();
    rst = 1'b0; pin0 = 8'h05; pst0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_outs", 32'(outs()), 32'h0);
    check("reset_rdata", 32'(crdata), 32'h0);
    pin0 = '0; pst0 = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; pin0 = '0; pin1 = '0; pst0 = 1'b0; pst1 = 1'b0;
    caddr = '0; cwdata = '0; cvalid = 1'b0; crw = 1'b0;

    // Basic forward in0 -> out0 and register reset values
    do_reset();
    for (int k = 0; k < 7; k++) tbl.push_back(mk(b22[k], k == 0, 8'h00, 1'b0, (k == 6) ? e_ack(1'b1, 1'b0) : 22'h0));
    for (int k = 0; k < 7; k++) tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(k == 0, b22[k])));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 22'h0));
    run_table("fwd7");
    chk_reg(8'h05, 8'h01, "fwd0_after7");
    chk_reg(8'h00, 8'h03, "ctrl_rst");
    chk_reg(8'h01, 8'h00, "route0_rst");
    chk_reg(8'h02, 8'h01, "route1_rst");
    chk_reg(8'h03, 8'h00, "drop0_rst");
    chk_reg(8'h07, 8'h00, "unmapped");

    // Reroute in0 to out1
    do_reset();
    cfg_wr(8'h01, 8'h01);
    tbl.push_back(mk(8'h02, 1'b1, 8'h00, 1'b0, 22'h0));
    tbl.push_back(mk(8'hAA, 1'b0, 8'h00, 1'b0, 22'h0));
    tbl.push_back(mk(8'hBB, 1'b0, 8'h00, 1'b0, e_ack(1'b1, 1'b0)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o1(1'b1, 8'h02)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o1(1'b0, 8'hAA)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o1(1'b0, 8'hBB)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 22'h0));
    run_table("route1");
    chk_reg(8'h05, 8'h00, "fwd0_route");
    chk_reg(8'h06, 8'h01, "fwd1_route");
    @(posedge clk); #1;
    check("rdata_hold", 32'(crdata), 32'h01);

    // Contention on out0: round-robin, back-to-back, no drops
    do_reset();
    cfg_wr(8'h02, 8'h00);
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b1, e_ack(1'b1, 1'b1)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b1, 8'h00)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b1, 8'h00)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 22'h0));
    run_table("contend0");
    chk_reg(8'h03, 8'h00, "drop0_contend");
    chk_reg(8'h04, 8'h00, "drop1_contend");
    chk_reg(8'h05, 8'h02, "fwd0_contend");
    tbl.push_back(mk(8'h01, 1'b1, 8'h01, 1'b1, 22'h0));
    tbl.push_back(mk(8'hA0, 1'b0, 8'hB1, 1'b0, e_ack(1'b1, 1'b1)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b1, 8'h01)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b0, 8'hB1)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b1, 8'h01)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b0, 8'hA0)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 22'h0));
    run_table("contend_rr");

    // Oversize drop (start inside the swallowed bytes is data), then immediate accept
    do_reset();
    tbl.push_back(mk(8'h10, 1'b1, 8'h00, 1'b0, 22'h0));
    for (int k = 1; k <= 16; k++) tbl.push_back(mk(8'(k), k == 5, 8'h00, 1'b0, 22'h0));
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, e_ack(1'b1, 1'b0)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b1, 8'h00)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 22'h0));
    run_table("len16_drop");
    chk_reg(8'h03, 8'h01, "drop0_len16");
    chk_reg(8'h04, 8'h00, "drop1_len16");
    // Max length packet, with a start pulse inside the payload
    tbl.push_back(mk(8'h0F, 1'b1, 8'h00, 1'b0, 22'h0));
    for (int k = 1; k <= 15; k++)
      tbl.push_back(mk(8'(k * 7), k == 3, 8'h00, 1'b0, (k == 15) ? e_ack(1'b1, 1'b0) : 22'h0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b1, 8'h0F)));
    for (int k = 1; k <= 15; k++) tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b0, 8'(k * 7))));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 22'h0));
    run_table("len15");
    // Disabled port ignores start without counting a drop; RO writes ignored
    cfg_wr(8'h00, 8'h02);
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 22'h0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 22'h0));
    run_table("disabled");
    cfg_wr(8'h03, 8'hFF);
    chk_reg(8'h03, 8'h01, "drop0_disabled");
    chk_reg(8'h00, 8'h02, "ctrl_wr");
    cfg_wr(8'h00, 8'h03);

    // Second start while buffer waits for a busy output is dropped
    do_reset();
    cfg_wr(8'h02, 8'h00);
    tbl.push_back(mk(8'h00, 1'b0, 8'h05, 1'b1, 22'h0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h11, 1'b0, 22'h0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h22, 1'b0, 22'h0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h33, 1'b0, 22'h0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h44, 1'b0, 22'h0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h55, 1'b0, e_ack(1'b0, 1'b1)));
    tbl.push_back(mk(8'h01, 1'b1, 8'h00, 1'b0, e_o0(1'b1, 8'h05)));
    tbl.push_back(mk(8'h77, 1'b0, 8'h00, 1'b0, e_ack(1'b1, 1'b0) | e_o0(1'b0, 8'h11)));
    tbl.push_back(mk(8'h01, 1'b1, 8'h00, 1'b0, e_o0(1'b0, 8'h22)));
    tbl.push_back(mk(8'h99, 1'b0, 8'h00, 1'b0, e_o0(1'b0, 8'h33)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b0, 8'h44)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b0, 8'h55)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b1, 8'h01)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b0, 8'h77)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 22'h0));
    run_table("busy_drop");
    chk_reg(8'h03, 8'h01, "drop0_busy");
    chk_reg(8'h04, 8'h00, "drop1_busy");
    chk_reg(8'h05, 8'h02, "fwd0_busy");

    // Reset mid-transmission
    do_reset();
    cfg_wr(8'h00, 8'h01);
    cfg_wr(8'h02, 8'h00);
    tbl.push_back(mk(8'h03, 1'b1, 8'h00, 1'b0, 22'h0));
    tbl.push_back(mk(8'h01, 1'b0, 8'h00, 1'b0, 22'h0));
    tbl.push_back(mk(8'h02, 1'b0, 8'h00, 1'b0, 22'h0));
    tbl.push_back(mk(8'h03, 1'b0, 8'h00, 1'b0, e_ack(1'b1, 1'b0)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b1, 8'h03)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b0, 8'h01)));
    run_table("pre_rst");
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_outs", 32'(outs()), 32'h0);
    rst = 1'b1;
    chk_reg(8'h00, 8'h03, "ctrl_after_rst");
    chk_reg(8'h02, 8'h01, "route1_after_rst");
    chk_reg(8'h01, 8'h00, "route0_after_rst");
    chk_reg(8'h05, 8'h00, "fwd0_after_rst");
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, e_ack(1'b1, 1'b0)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, e_o0(1'b1, 8'h00)));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 22'h0));
    run_table("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
